// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control constants: ALU codes, opcodes, control FSM state encoding
// and the opcode class record produced by opcode_class_decode.
package cpu_ctrl_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_NOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic r_type;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode -> one-hot instruction class, plus the ALU code and
// immediate-extension mode used by the I-type execute step.
module opcode_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu,
  output logic       imm_zext
);

  always_comb begin
    op_class = '0;
    imm_alu  = ALU_ADD;
    imm_zext = 1'b0;
    case (opcode)
      OP_R:           op_class.r_type = 1'b1;
      OP_J:           op_class.jump   = 1'b1;
      OP_BEQ, OP_BNE: op_class.branch = 1'b1;
      OP_LW:          op_class.load   = 1'b1;
      OP_SW:          op_class.store  = 1'b1;
      OP_ADDI:        op_class.imm    = 1'b1;
      OP_SLTI: begin
        op_class.imm = 1'b1;
        imm_alu      = ALU_SLT;
      end
      OP_ANDI: begin
        op_class.imm = 1'b1;
        imm_alu      = ALU_AND;
        imm_zext     = 1'b1;
      end
      OP_ORI: begin
        op_class.imm = 1'b1;
        imm_alu      = ALU_OR;
        imm_zext     = 1'b1;
      end
      default:        op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-subset main control FSM (Moore; FETCH ir/pc writes gated by mem_ready).
// Unknown opcodes trap when MC_CONTROL_ILLEGAL_TRAP_EN is defined, else run as a NOP.
module multicycle_main_control
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [3:0] state_out,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic [5:0] dec_opcode;
  op_class_t  op_class;
  logic [2:0] imm_alu;
  logic       imm_zext;

  // The IR settles after FETCH, so DECODE reads the live opcode; later states use the copy.
  assign dec_opcode = (state_q == S_DECODE) ? opcode : opcode_q;

  opcode_class_decode u_dec (
    .opcode   (dec_opcode),
    .op_class (op_class),
    .imm_alu  (imm_alu),
    .imm_zext (imm_zext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op_class.r_type)                       state_d = S_EXEC_R;
        else if (op_class.imm)                     state_d = S_EXEC_I;
        else if (op_class.load || op_class.store)  state_d = S_ADDR;
        else if (op_class.branch)                  state_d = S_BRANCH;
        else if (op_class.jump)                    state_d = S_JUMP;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        else if (op_class.illegal)                 state_d = S_TRAP;
`else
        else if (op_class.illegal)                 state_d = S_FETCH;
`endif
        else                                       state_d = S_FETCH;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = op_class.load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALUop         = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    case (state_q)
      S_IDLE, S_TRAP: ALUop = 3'b000;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUop     = ALU_RTYPE;
      end
      S_WB_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = imm_alu;
        ext_zero  = imm_zext;
      end
      S_WB_I: reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (opcode_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule
